// File: rtl/coo_enc_dlk_pkg.sv
// Shared types and the round-robin pick helper for the coo_enc deadlock report controller.
package coo_enc_dlk_pkg;

  typedef enum logic [0:0] {ST_IDLE, ST_REPORT} dlk_state_e;

  localparam int MAX_MON = 32;

  // First set bit of mask at or above ptr, wrapping at nMon; 0 when the mask is empty.
  function automatic int rr_pick(input logic [MAX_MON-1:0] mask, input int ptr, input int nMon);
    int pick;
    int j;
    logic found;
    pick  = 0;
    found = 1'b0;
    for (int i = 0; i < MAX_MON; i++) begin
      if (i < nMon && !found) begin
        j = (ptr + i) % nMon;
        if (mask[j]) begin
          pick  = j;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/coo_enc_dlk_persist_cnt.sv
// Persistence filter for one monitor: confirms after THRESH consecutive blocked cycles.
module coo_enc_dlk_persist_cnt #(
  parameter int THRESH = 16,
  parameter int CNT_W  = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic block,
  input  logic hold,
  output logic confirm
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(THRESH - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en || !block || hold) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires only on the edge that completes the THRESH-th consecutive blocked cycle.
  assign confirm = en && block && !hold && (cnt_q == LAST);

endmodule

// File: rtl/coo_enc_deadlock_report_ctrl.sv
// Filters monitor block flags, reports confirmed monitors round-robin and keeps a sticky deadlock flag.
module coo_enc_deadlock_report_ctrl
  import coo_enc_dlk_pkg::*;
#(
  parameter  int NUM_MON = 4,
  parameter  int THRESH  = 16,
  parameter  int CNT_W   = 8,
  localparam int IDX_W   = $clog2(NUM_MON)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [NUM_MON-1:0] mon_block,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [IDX_W-1:0]   rpt_idx,
  output logic [NUM_MON-1:0] pending,
  output logic               deadlock
);

  dlk_state_e         state_q, state_d;
  logic [NUM_MON-1:0] pending_q, pending_d;
  logic [NUM_MON-1:0] reported_q, reported_d;
  logic               deadlock_q, deadlock_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   rpt_idx_q, rpt_idx_d;
  logic               rpt_valid_q, rpt_valid_d;
  logic [NUM_MON-1:0] confirm;
  logic [NUM_MON-1:0] hs_mask;
  logic [MAX_MON-1:0] mask_ext;
  logic               handshake;

  for (genvar g = 0; g < NUM_MON; g++) begin : g_cnt
    coo_enc_dlk_persist_cnt #(
      .THRESH (THRESH),
      .CNT_W  (CNT_W)
    ) u_cnt (
      .clock   (clock),
      .reset   (reset),
      .clr     (clear),
      .en      (enable),
      .block   (mon_block[g]),
      .hold    (reported_q[g]),
      .confirm (confirm[g])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (|pending_q) state_d = ST_REPORT;
        ST_REPORT: if (rpt_ready)  state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Clear wins over everything, including a handshake or confirmation in the same cycle.
  always_comb begin
    pending_d   = pending_q;
    reported_d  = reported_q;
    deadlock_d  = deadlock_q;
    rr_ptr_d    = rr_ptr_q;
    rpt_idx_d   = rpt_idx_q;
    rpt_valid_d = rpt_valid_q;
    hs_mask     = '0;
    mask_ext    = '0;
    mask_ext[NUM_MON-1:0] = pending_q;
    handshake   = (state_q == ST_REPORT) && rpt_valid_q && rpt_ready && !clear;
    if (handshake) hs_mask[rpt_idx_q] = 1'b1;
    if (clear) begin
      pending_d   = '0;
      reported_d  = '0;
      deadlock_d  = 1'b0;
      rpt_valid_d = 1'b0;
    end else begin
      pending_d  = (pending_q | confirm) & ~hs_mask;
      reported_d = reported_q | hs_mask;
      deadlock_d = deadlock_q | (|confirm);
      if (state_q == ST_IDLE && |pending_q) begin
        rpt_idx_d   = IDX_W'(rr_pick(mask_ext, int'(rr_ptr_q), NUM_MON));
        rpt_valid_d = 1'b1;
      end
      if (handshake) begin
        rr_ptr_d    = (rpt_idx_q == IDX_W'(NUM_MON - 1)) ? '0 : rpt_idx_q + 1'b1;
        rpt_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q   <= '0;
      reported_q  <= '0;
      deadlock_q  <= 1'b0;
      rr_ptr_q    <= '0;
      rpt_idx_q   <= '0;
      rpt_valid_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      reported_q  <= reported_d;
      deadlock_q  <= deadlock_d;
      rr_ptr_q    <= rr_ptr_d;
      rpt_idx_q   <= rpt_idx_d;
      rpt_valid_q <= rpt_valid_d;
    end
  end

  assign rpt_valid = rpt_valid_q;
  assign rpt_idx   = rpt_idx_q;
  assign pending   = pending_q;
  assign deadlock  = deadlock_q;

endmodule

// File: tb/tb_coo_enc_deadlock_report_ctrl.sv
// Self-checking bench: directed scenarios with fixed cycle expectations plus random traffic
// compared against a behavioural model of run lengths, pending/reported sets and the report slot.
module tb_coo_enc_deadlock_report_ctrl;

  localparam int NUM_MON = 4;
  localparam int THRESH  = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       clear;
  logic [3:0] mon_block;
  logic       rpt_valid;
  logic       rpt_ready;
  logic [1:0] rpt_idx;
  logic [3:0] pending;
  logic       deadlock;

  int checks = 0;
  int errors = 0;

  int         runLen[NUM_MON];
  logic [3:0] mPend, mRep;
  logic       mDl, mBusy;
  int         mIdx, mPtr;

  coo_enc_deadlock_report_ctrl #(
    .NUM_MON (NUM_MON),
    .THRESH  (THRESH),
    .CNT_W   (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .clear     (clear),
    .mon_block (mon_block),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .rpt_idx   (rpt_idx),
    .pending   (pending),
    .deadlock  (deadlock)
  );

  always #5 clock = ~clock;

  // Behavioural view of one clock edge, evaluated with the inputs present at that edge.
  task automatic modelEdge();
    logic [3:0] conf;
    logic       hs, pickNow;
    int         pickIdx, j;
    if (reset) begin
      for (int i = 0; i < NUM_MON; i++) runLen[i] = 0;
      mPend = '0; mRep = '0; mDl = 0; mBusy = 0; mIdx = 0; mPtr = 0;
    end else if (clear) begin
      for (int i = 0; i < NUM_MON; i++) runLen[i] = 0;
      mPend = '0; mRep = '0; mDl = 0; mBusy = 0;
    end else begin
      hs      = mBusy && rpt_ready;
      pickNow = !mBusy && (mPend != 0);
      pickIdx = -1;
      for (int k = 0; k < NUM_MON; k++) begin
        j = (mPtr + k) % NUM_MON;
        if (pickIdx < 0 && mPend[j]) pickIdx = j;
      end
      for (int i = 0; i < NUM_MON; i++) begin
        conf[i]   = enable && mon_block[i] && !mRep[i] && (runLen[i] == THRESH - 1);
        runLen[i] = (enable && mon_block[i] && !mRep[i]) ? runLen[i] + 1 : 0;
      end
      mPend = mPend | conf;
      if (conf != 0) mDl = 1;
      if (hs) begin
        mPend[mIdx] = 0;
        mRep[mIdx]  = 1;
        mPtr  = (mIdx + 1) % NUM_MON;
        mBusy = 0;
      end else if (pickNow) begin
        mIdx  = pickIdx;
        mBusy = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    modelEdge();
    #1;
  endtask

  task automatic doReset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    enable = 1; clear = 0; mon_block = '0; rpt_ready = 0;
    doReset();
    checks++;
    if ({rpt_valid, rpt_idx, pending, deadlock} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset: got v=%b i=%0d p=%b d=%b, want all zero", rpt_valid, rpt_idx, pending, deadlock);
    end
  endtask

  task automatic test_single();
    logic [5:0] exp;
    mon_block = 4'b0100; rpt_ready = 1; enable = 1;
    doReset();
    for (int c = 0; c <= 20; c++) begin
      exp = {(c == 17), ((c == 16 || c == 17) ? 4'b0100 : 4'b0000), (c >= 16)};
      checks++;
      if ({rpt_valid, pending, deadlock} !== exp) begin
        errors++;
        $display("[TB] FAIL single c%0d: got v/p/d=%b want %b", c, {rpt_valid, pending, deadlock}, exp);
      end
      if (c == 17) begin
        checks++;
        if (rpt_idx !== 2'd2) begin
          errors++;
          $display("[TB] FAIL single_idx: got %0d want 2", rpt_idx);
        end
      end
      tick();
    end
  endtask

  task automatic test_glitch();
    mon_block = '0; rpt_ready = 1;
    doReset();
    for (int c = 0; c <= 33; c++) begin
      mon_block[0] = (c < 15) || (c >= 16 && c < 31);
      checks++;
      if ({rpt_valid, pending, deadlock} !== 6'b0) begin
        errors++;
        $display("[TB] FAIL glitch c%0d: got v/p/d=%b want 000000", c, {rpt_valid, pending, deadlock});
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] expP;
    mon_block = 4'hF; rpt_ready = 0;
    doReset();
    repeat (16) tick();
    checks++;
    if ({rpt_valid, pending, deadlock} !== 6'b0_1111_1) begin
      errors++;
      $display("[TB] FAIL rr_confirm: got v/p/d=%b want 011111", {rpt_valid, pending, deadlock});
    end
    tick();
    for (int s = 0; s < 5; s++) begin
      checks++;
      if ({rpt_valid, rpt_idx} !== 3'b1_00) begin
        errors++;
        $display("[TB] FAIL rr_stall s%0d: got v=%b i=%0d want v=1 i=0", s, rpt_valid, rpt_idx);
      end
      tick();
    end
    rpt_ready = 1;
    for (int k = 0; k < NUM_MON; k++) begin
      checks++;
      if ({rpt_valid, rpt_idx} !== {1'b1, 2'(k)}) begin
        errors++;
        $display("[TB] FAIL rr_order k%0d: got v=%b i=%0d want v=1 i=%0d", k, rpt_valid, rpt_idx, k);
      end
      tick();
      expP = 4'hF << (k + 1);
      checks++;
      if ({rpt_valid, pending} !== {1'b0, expP}) begin
        errors++;
        $display("[TB] FAIL rr_gap k%0d: got v=%b p=%b want v=0 p=%b", k, rpt_valid, pending, expP);
      end
      tick();
    end
    checks++;
    if ({rpt_valid, pending, deadlock} !== 6'b0_0000_1) begin
      errors++;
      $display("[TB] FAIL rr_done: got v/p/d=%b want 000001", {rpt_valid, pending, deadlock});
    end
  endtask

  task automatic test_clear_report();
    mon_block = 4'b0001; rpt_ready = 0;
    doReset();
    repeat (17) tick();
    checks++;
    if ({rpt_valid, rpt_idx} !== 3'b1_00) begin
      errors++;
      $display("[TB] FAIL clr_pre: got v=%b i=%0d want v=1 i=0", rpt_valid, rpt_idx);
    end
    clear = 1; rpt_ready = 1;
    tick();
    clear = 0;
    checks++;
    if ({rpt_valid, pending, deadlock} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL clr_after: got v/p/d=%b want 000000", {rpt_valid, pending, deadlock});
    end
    repeat (15) tick();
    checks++;
    if (pending !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL clr_early: got p=%b want 0000", pending);
    end
    tick();
    checks++;
    if ({rpt_valid, pending, deadlock} !== 6'b0_0001_1) begin
      errors++;
      $display("[TB] FAIL clr_reconf: got v/p/d=%b want 000011", {rpt_valid, pending, deadlock});
    end
    tick();
    checks++;
    if ({rpt_valid, rpt_idx} !== 3'b1_00) begin
      errors++;
      $display("[TB] FAIL clr_rerpt: got v=%b i=%0d want v=1 i=0", rpt_valid, rpt_idx);
    end
    tick();
  endtask

  task automatic test_enable();
    enable = 0; mon_block = 4'hF; rpt_ready = 1;
    doReset();
    for (int c = 0; c < 100; c++) begin
      checks++;
      if ({rpt_valid, pending, deadlock} !== 6'b0) begin
        errors++;
        $display("[TB] FAIL enable_off c%0d: got v/p/d=%b want 000000", c, {rpt_valid, pending, deadlock});
      end
      tick();
    end
    enable = 1;
    repeat (15) tick();
    checks++;
    if (pending !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL enable_early: got p=%b want 0000", pending);
    end
    tick();
    checks++;
    if ({pending, deadlock} !== 5'b1111_1) begin
      errors++;
      $display("[TB] FAIL enable_conf: got p/d=%b want 11111", {pending, deadlock});
    end
  endtask

  task automatic test_reset_mid();
    enable = 1; mon_block = 4'b0010; rpt_ready = 0;
    doReset();
    repeat (17) tick();
    checks++;
    if ({rpt_valid, rpt_idx} !== 3'b1_01) begin
      errors++;
      $display("[TB] FAIL rst_pre: got v=%b i=%0d want v=1 i=1", rpt_valid, rpt_idx);
    end
    doReset();
    checks++;
    if ({rpt_valid, rpt_idx, pending, deadlock} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL rst_mid: got v=%b i=%0d p=%b d=%b want all zero", rpt_valid, rpt_idx, pending, deadlock);
    end
    repeat (16) tick();
    checks++;
    if ({rpt_valid, pending, deadlock} !== 6'b0_0010_1) begin
      errors++;
      $display("[TB] FAIL rst_resume: got v/p/d=%b want 000101", {rpt_valid, pending, deadlock});
    end
    tick();
    checks++;
    if ({rpt_valid, rpt_idx} !== 3'b1_01) begin
      errors++;
      $display("[TB] FAIL rst_rerpt: got v=%b i=%0d want v=1 i=1", rpt_valid, rpt_idx);
    end
  endtask

  task automatic test_random();
    enable = 1; clear = 0; mon_block = '0; rpt_ready = 0;
    doReset();
    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom_range(0, 999) == 0);
      clear     = ($urandom_range(0, 79) == 0);
      enable    = ($urandom_range(0, 39) != 0);
      rpt_ready = $urandom_range(0, 1) == 1;
      for (int i = 0; i < NUM_MON; i++) begin
        if ($urandom_range(0, 39) == 0) mon_block[i] = ~mon_block[i];
      end
      tick();
      checks++;
      if ({rpt_valid, pending, deadlock} !== {mBusy, mPend, mDl}) begin
        errors++;
        $display("[TB] FAIL random c%0d: got v/p/d=%b want %b", c, {rpt_valid, pending, deadlock}, {mBusy, mPend, mDl});
      end
      if (mBusy) begin
        checks++;
        if (rpt_idx !== 2'(mIdx)) begin
          errors++;
          $display("[TB] FAIL random_idx c%0d: got %0d want %0d", c, rpt_idx, mIdx);
        end
      end
    end
    reset = 0; clear = 0;
  endtask

  initial begin
    reset = 1; enable = 1; clear = 0; mon_block = '0; rpt_ready = 0;
    test_reset();
    test_single();
    test_glitch();
    test_round_robin();
    test_clear_report();
    test_enable();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
